// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding decode through a 2-entry {instr, PC} buffer.
// Ports: Clk, Reset (async, active-high); Halt, Redirect, RedirectPC from the pipeline;
// MemReady, MemExecute, MemAddr (command side) and MemDataIn, MemDataReady (return side) of memory;
// InstrValid, InstrReady, Instr, InstrPC (decode handshake); Halted (stopped, nothing in flight).
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Halt,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        MemReady,
  output logic        MemExecute,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        Halted
);
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
  state_t state;
  logic [31:0] fetchPC, reqPC, instr0, instr1, pc0, pc1;
  logic [1:0] count, countAfterPop;
  logic discard, pop, push, issue;
  assign pop = InstrValid && InstrReady;
  assign countAfterPop = count - {1'b0, pop};
  // Reset gating keeps the command strobe quiet while the FSM is held in IDLE.
  assign issue = !Reset && state == IDLE && !Halt && !Redirect && MemReady && countAfterPop < 2'd2;
  // A word arriving alongside a redirect belongs to the old stream and is dropped.
  assign push = state == WAIT && MemDataReady && !discard && !Redirect;
  assign MemExecute = issue;
  assign MemAddr = issue ? fetchPC : 32'h0;
  assign InstrValid = count != 2'd0;
  assign Instr = instr0;
  assign InstrPC = pc0;
  assign Halted = state == HALTED;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      fetchPC <= RESET_VECTOR;
      reqPC <= '0;
      discard <= 1'b0;
      count <= '0;
      instr0 <= '0;
      instr1 <= '0;
      pc0 <= '0;
      pc1 <= '0;
    end else begin
      count <= Redirect ? 2'd0 : countAfterPop + {1'b0, push};
      fetchPC <= Redirect ? (RedirectPC & 32'hFFFF_FFFC) : issue ? fetchPC + 32'd4 : fetchPC;
      reqPC <= issue ? fetchPC : reqPC;
      // Head shifts on pop; a push lands in the slot left free after that pop.
      if (pop) begin
        instr0 <= instr1;
        pc0 <= pc1;
      end
      if (push && !countAfterPop[0]) begin
        instr0 <= MemDataIn;
        pc0 <= reqPC;
      end
      if (push && countAfterPop[0]) begin
        instr1 <= MemDataIn;
        pc1 <= reqPC;
      end
      case (state)
        IDLE: state <= Halt ? HALTED : issue ? WAIT : IDLE;
        WAIT: begin
          state <= MemDataReady ? (Halt ? HALTED : IDLE) : WAIT;
          // Redirect while a read is pending marks that read's word as stale.
          discard <= MemDataReady ? 1'b0 : (discard || Redirect);
        end
        HALTED: state <= Halt ? HALTED : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, corner sequences and random traffic checked against a queue-based fetch model.
module tb_fetch_unit;
  logic Clk = 1'b0, Reset = 1'b1, Halt = 1'b0, Redirect = 1'b0, MemReady = 1'b0;
  logic MemDataReady = 1'b0, InstrReady = 1'b0;
  logic [31:0] RedirectPC = '0, MemDataIn = '0;
  logic MemExecute, InstrValid, Halted;
  logic [31:0] MemAddr, Instr, InstrPC;
  logic ex1, iv1, h1;
  logic [31:0] ma1, i1, ip1;
  int total = 0, bad = 0;
  fetch_unit dut (.Clk(Clk), .Reset(Reset), .Halt(Halt), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .MemReady(MemReady), .MemExecute(MemExecute), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .MemDataReady(MemDataReady), .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .InstrPC(InstrPC), .Halted(Halted));
  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u1 (.Clk(Clk), .Reset(Reset), .Halt(Halt), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .MemReady(MemReady), .MemExecute(ex1), .MemAddr(ma1), .MemDataIn(MemDataIn),
    .MemDataReady(MemDataReady), .InstrValid(iv1), .InstrReady(InstrReady), .Instr(i1), .InstrPC(ip1),
    .Halted(h1));
  always #5 Clk = ~Clk;
  typedef struct { logic [31:0] ins, pc; } ent_t;
  ent_t q[$];
  logic [31:0] mPC = '0, mReqPC = '0;
  logic inflight = 1'b0, drop = 1'b0, mHalted = 1'b0, mPop, mExec;
  logic obsExec, obsValid, obsHalted, obsMdr;
  logic [31:0] obsAddr, obsInstr, obsPC, obsAddr1;
  logic autoMem = 1'b0;
  int memCnt = 0, lat = 1;
  logic [31:0] memA = '0;
  typedef struct { logic rst, halt, mrdy, mdr, irdy; logic [31:0] din; logic ex; logic [31:0] addr;
    logic val; logic [31:0] ins, pc; logic hl; } vec_t;
  vec_t tbl[12];
  function automatic vec_t mk(int rst, int halt, int mrdy, int mdr, int irdy, logic [31:0] din,
    int ex, logic [31:0] addr, int val, logic [31:0] ins, logic [31:0] pc, int hl);
    vec_t r;
    r.rst = rst != 0; r.halt = halt != 0; r.mrdy = mrdy != 0; r.mdr = mdr != 0; r.irdy = irdy != 0;
    r.din = din; r.ex = ex != 0; r.addr = addr; r.val = val != 0; r.ins = ins; r.pc = pc; r.hl = hl != 0;
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic modelCheck();
    mPop = q.size() > 0 && InstrReady;
    mExec = !Reset && !inflight && !mHalted && !Halt && !Redirect && MemReady && (q.size() - (mPop ? 1 : 0)) < 2;
    check("m_exec", 32'(obsExec), 32'(mExec));
    check("m_addr", obsAddr, mExec ? mPC : 32'h0);
    check("m_valid", 32'(obsValid), 32'(!Reset && q.size() > 0));
    check("m_halted", 32'(obsHalted), 32'(!Reset && mHalted));
    if (Reset) begin
      check("m_rst_instr", obsInstr, 32'h0);
      check("m_rst_pc", obsPC, 32'h0);
    end else if (q.size() > 0) begin
      check("m_instr", obsInstr, q[0].ins);
      check("m_pc", obsPC, q[0].pc);
    end
  endtask
  task automatic modelUpdate();
    if (Reset) begin
      q.delete(); mPC = 32'h0; inflight = 0; drop = 0; mHalted = 0;
    end else begin
      if (mPop && !Redirect) void'(q.pop_front());
      if (inflight && MemDataReady) begin
        if (!drop && !Redirect) q.push_back('{MemDataIn, mReqPC});
        inflight = 0; drop = 0; mHalted = Halt;
      end else if (inflight) begin
        if (Redirect) drop = 1;
      end else if (mHalted) mHalted = Halt;
      else if (Halt) mHalted = 1;
      if (Redirect) begin
        q.delete(); mPC = RedirectPC & 32'hFFFF_FFFC;
      end else if (mExec) begin
        inflight = 1; mReqPC = mPC; mPC = mPC + 32'd4;
      end
    end
  endtask
  task automatic tick();
    @(negedge Clk);
    obsExec = MemExecute; obsAddr = MemAddr; obsValid = InstrValid; obsInstr = Instr;
    obsPC = InstrPC; obsHalted = Halted; obsAddr1 = ma1; obsMdr = MemDataReady;
    modelCheck();
    @(posedge Clk);
    modelUpdate();
    #1;
    if (autoMem) begin
      if (obsExec) begin memCnt = lat; memA = obsAddr; end
      MemDataReady = 1'b0;
      if (memCnt > 0) begin
        memCnt--;
        if (memCnt == 0) begin MemDataReady = 1'b1; MemDataIn = memA ^ 32'h5A5A_A5A5; end
      end
    end
  endtask
  task automatic doReset();
    Reset = 1'b1; Halt = 1'b0; Redirect = 1'b0; MemDataReady = 1'b0; memCnt = 0;
    tick();
    Reset = 1'b0;
  endtask
  initial begin
    int n;
    logic found, sawValid;
    logic [31:0] a0, a1, b0, b1;
    //            rst hlt mrd mdr ird din           ex addr   val ins           pc      hl
    tbl[0]  = mk(1, 0, 1, 0, 1, 32'h0,          0, 32'h0, 0, 32'h0,          32'h0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 32'h0,          1, 32'h0, 0, 32'h0,          32'h0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 1, 32'hA000_0000, 0, 32'h0, 0, 32'h0,          32'h0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 1, 32'h0,          1, 32'h4, 1, 32'hA000_0000, 32'h0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 1, 32'hA000_0001, 0, 32'h0, 0, 32'h0,          32'h0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 1, 32'h0,          1, 32'h8, 1, 32'hA000_0001, 32'h4, 0);
    tbl[6]  = mk(0, 0, 1, 1, 1, 32'hA000_0002, 0, 32'h0, 0, 32'h0,          32'h0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0,          0, 32'h0, 1, 32'hA000_0002, 32'h8, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 32'h0,          0, 32'h0, 1, 32'hA000_0002, 32'h8, 0);
    tbl[9]  = mk(0, 1, 1, 0, 1, 32'h0,          0, 32'h0, 1, 32'hA000_0002, 32'h8, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 32'h0,          0, 32'h0, 0, 32'h0,          32'h0, 1);
    tbl[11] = mk(0, 0, 1, 0, 0, 32'h0,          1, 32'hC, 0, 32'h0,          32'h0, 0);
    for (int i = 0; i < 12; i++) begin
      Reset = tbl[i].rst; Halt = tbl[i].halt; MemReady = tbl[i].mrdy; MemDataReady = tbl[i].mdr;
      MemDataIn = tbl[i].din; InstrReady = tbl[i].irdy; Redirect = 1'b0;
      tick();
      check("t_exec", 32'(obsExec), 32'(tbl[i].ex));
      check("t_addr", obsAddr, tbl[i].addr);
      check("t_valid", 32'(obsValid), 32'(tbl[i].val));
      check("t_halted", 32'(obsHalted), 32'(tbl[i].hl));
      if (tbl[i].val || tbl[i].rst) begin
        check("t_instr", obsInstr, tbl[i].ins);
        check("t_pc", obsPC, tbl[i].pc);
      end
    end
    autoMem = 1'b1;
    // two-entry backpressure
    doReset(); MemReady = 1'b1; InstrReady = 1'b0; lat = 1; n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n += int'(obsExec); end
    check("bp_issues", n, 2);
    check("bp_valid", 32'(obsValid), 32'h1);
    InstrReady = 1'b1;
    tick();
    check("bp_pc0", obsPC, 32'h0);
    check("bp_ins0", obsInstr, 32'h5A5A_A5A5);
    tick();
    check("bp_pc1", obsPC, 32'h4);
    check("bp_ins1", obsInstr, 32'h4 ^ 32'h5A5A_A5A5);
    // redirect during an outstanding read
    doReset(); MemReady = 1'b1; InstrReady = 1'b1; lat = 3;
    tick();
    check("rd_issue", 32'(obsExec), 32'h1);
    Redirect = 1'b1; RedirectPC = 32'h0000_1003;
    tick();
    Redirect = 1'b0; found = 0; sawValid = 0; a0 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawValid |= obsValid;
      if (obsExec) begin found = 1; a0 = obsAddr; break; end
    end
    check("rd_found", 32'(found), 32'h1);
    check("rd_addr", a0, 32'h0000_1000);
    check("rd_novalid", 32'(sawValid), 32'h0);
    // reset-vector wrap on the second instance, sequential start on the first
    doReset(); MemReady = 1'b1; InstrReady = 1'b1; lat = 1; n = 0;
    a0 = '1; a1 = '1; b0 = '1; b1 = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obsExec && n == 0) begin a0 = obsAddr1; b0 = obsAddr; end
      if (obsExec && n == 1) begin a1 = obsAddr1; b1 = obsAddr; end
      n += int'(obsExec);
    end
    check("wrap_a0", a0, 32'hFFFF_FFFC);
    check("wrap_a1", a1, 32'h0000_0000);
    check("seq_b0", b0, 32'h0);
    check("seq_b1", b1, 32'h4);
    // halt while waiting, then resume
    doReset(); MemReady = 1'b1; InstrReady = 1'b0; lat = 2;
    tick();
    check("h_issue", 32'(obsExec), 32'h1);
    Halt = 1'b1; found = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (obsMdr) begin found = 1; break; end end
    check("h_data", 32'(found), 32'h1);
    tick();
    check("h_halted", 32'(obsHalted), 32'h1);
    check("h_valid", 32'(obsValid), 32'h1);
    check("h_pc", obsPC, 32'h0);
    tick();
    check("h_noissue", 32'(obsExec), 32'h0);
    Halt = 1'b0;
    tick();
    found = 0; a0 = '0;
    for (int i = 0; i < 4; i++) begin tick(); if (obsExec) begin found = 1; a0 = obsAddr; break; end end
    check("h_resume", 32'(found), 32'h1);
    check("h_resume_addr", a0, 32'h4);
    // reset pulse mid-read followed by a stray data strobe
    doReset(); MemReady = 1'b1; InstrReady = 1'b1; lat = 3;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; MemReady = 1'b0; memCnt = 0; MemDataReady = 1'b1; MemDataIn = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin tick(); check("rs_novalid", 32'(obsValid), 32'h0); end
    MemReady = 1'b1;
    tick();
    check("rs_exec", 32'(obsExec), 32'h1);
    check("rs_addr", obsAddr, 32'h0);
    check("rs_addr1", obsAddr1, 32'hFFFF_FFFC);
    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      Reset = $urandom_range(0, 99) == 0;
      Halt = $urandom_range(0, 9) == 0;
      Redirect = $urandom_range(0, 19) == 0;
      RedirectPC = $urandom;
      MemReady = $urandom_range(0, 9) < 7;
      InstrReady = $urandom_range(0, 9) < 6;
      lat = $urandom_range(1, 3);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
